// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fft_pkg
// Brief   : Shared constants and FSM state encoding for the FFT butterfly
//           sequencer (fft_bf_ctrl and fft_addr_gen).
// Revision: 1.0 - initial release
// ============================================================================
package fft_pkg;

  localparam int N         = 32;  // FFT points
  localparam int LOG2N     = 5;   // number of radix-2 stages
  localparam int PHASES    = 4;   // MAC cycles per butterfly
  localparam int SYNC_CYC  = 2;   // pipeline settle cycles between stages
  localparam int DRAIN_CYC = 2;   // pipeline flush cycles after last stage

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    SYNC  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/fft_addr_gen.sv
`default_nettype none
// ============================================================================
// Module  : fft_addr_gen
// Brief   : Combinational butterfly operand address and twiddle index
//           generator for an in-place radix-2 32-point FFT.
// Revision: 1.0 - initial release
// ============================================================================
module fft_addr_gen (
  input  logic [2:0] stage_i,
  input  logic [3:0] bf_idx_i,
  output logic [4:0] addr_a_o,
  output logic [4:0] addr_b_o,
  output logic [3:0] tw_idx_o
);

  logic [4:0] w_span;
  logic [4:0] w_pos;
  logic [4:0] w_grp;

  // Split the butterfly index into group and in-group position, then
  // spread groups apart by twice the span to leave room for the B operand.
  always_comb begin
    w_span   = 5'd1 << stage_i;
    w_pos    = {1'b0, bf_idx_i} & (w_span - 5'd1);
    w_grp    = {1'b0, bf_idx_i} >> stage_i;
    addr_a_o = (w_grp << (stage_i + 3'd1)) | w_pos;
    addr_b_o = addr_a_o + w_span;
    // pos < span, so shifting by (4 - stage) always stays within 4 bits
    tw_idx_o = w_pos[3:0] << (3'd4 - stage_i);
  end

endmodule
`default_nettype wire

// File: rtl/fft_bf_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : fft_bf_ctrl
// Brief   : Butterfly sequencer for a 32-point radix-2 FFT: walks stages and
//           butterflies, issues operand/twiddle addresses, phase counters and
//           a delayed write-back strobe with captured write addresses.
// Revision: 1.0 - initial release
// ============================================================================
module fft_bf_ctrl #(
  parameter int N      = fft_pkg::N,
  parameter int PHASES = fft_pkg::PHASES
) (
  input  logic       clk_MAC,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [2:0] count,
  output logic [2:0] count_reg,
  output logic       flag,
  output logic [2:0] stage,
  output logic [4:0] addr_a,
  output logic [4:0] addr_b,
  output logic [3:0] tw_idx,
  output logic       wr_en,
  output logic [4:0] wr_addr_a,
  output logic [4:0] wr_addr_b
);

  import fft_pkg::*;

  localparam int LAST_STAGE = $clog2(N) - 1;
  localparam int LAST_BF    = N / 2 - 1;

  state_e     state_q;
  logic [1:0] cyc_q;
  logic [3:0] bf_idx_q;
  logic [2:0] count_q;
  logic [2:0] count_reg_q;
  logic [2:0] stage_q;
  logic       flag_q;
  logic       busy_q;
  logic       done_q;
  logic       wr_en_q;
  logic [4:0] wr_addr_a_q;
  logic [4:0] wr_addr_b_q;

  logic [4:0] w_addr_a;
  logic [4:0] w_addr_b;
  logic [3:0] w_tw_idx;

  fft_addr_gen u_addr_gen (
    .stage_i  (stage_q),
    .bf_idx_i (bf_idx_q),
    .addr_a_o (w_addr_a),
    .addr_b_o (w_addr_b),
    .tw_idx_o (w_tw_idx)
  );

  // Sequencer FSM with phase/butterfly/stage counters and write-back pipeline
  always_ff @(posedge clk_MAC) begin
    if (rst) begin
      state_q     <= IDLE;
      cyc_q       <= 2'd0;
      bf_idx_q    <= 4'd0;
      count_q     <= 3'd0;
      count_reg_q <= 3'd0;
      stage_q     <= 3'd0;
      flag_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_a_q <= 5'd0;
      wr_addr_b_q <= 5'd0;
    end else begin
      count_reg_q <= count_q;
      wr_en_q     <= flag_q;
      // Operands of the butterfly finishing this cycle are written back next
      if (flag_q) begin
        wr_addr_a_q <= w_addr_a;
        wr_addr_b_q <= w_addr_b;
      end
      done_q <= 1'b0;
      flag_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= RUN;
            busy_q   <= 1'b1;
            count_q  <= 3'd0;
            stage_q  <= 3'd0;
            bf_idx_q <= 4'd0;
          end
        end
        RUN: begin
          if (count_q == 3'(PHASES - 1)) begin
            count_q  <= 3'd0;
            bf_idx_q <= bf_idx_q + 4'd1;
            if (bf_idx_q == 4'(LAST_BF)) begin
              cyc_q   <= 2'd0;
              state_q <= (stage_q < 3'(LAST_STAGE)) ? SYNC : DRAIN;
            end
          end else begin
            count_q <= count_q + 3'd1;
            flag_q  <= (count_q == 3'(PHASES - 2));
          end
        end
        SYNC: begin
          if (cyc_q == 2'(SYNC_CYC - 1)) begin
            stage_q  <= stage_q + 3'd1;
            bf_idx_q <= 4'd0;
            state_q  <= RUN;
          end else begin
            cyc_q <= cyc_q + 2'd1;
          end
        end
        DRAIN: begin
          if (cyc_q == 2'(DRAIN_CYC - 1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            cyc_q <= cyc_q + 2'd1;
          end
        end
        DONE: begin
          state_q  <= IDLE;
          busy_q   <= 1'b0;
          stage_q  <= 3'd0;
          bf_idx_q <= 4'd0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Address outputs are forced to zero while idle so an idle block presents
  // a clean bus (stage 0 / butterfly 0 would otherwise show addr_b = 1).
  assign addr_a    = busy_q ? w_addr_a : 5'd0;
  assign addr_b    = busy_q ? w_addr_b : 5'd0;
  assign tw_idx    = busy_q ? w_tw_idx : 4'd0;
  assign busy      = busy_q;
  assign done      = done_q;
  assign count     = count_q;
  assign count_reg = count_reg_q;
  assign flag      = flag_q;
  assign stage     = stage_q;
  assign wr_en     = wr_en_q;
  assign wr_addr_a = wr_addr_a_q;
  assign wr_addr_b = wr_addr_b_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_bf_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_fft_bf_ctrl
// Brief   : Directed self-checking bench for fft_bf_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fft_bf_ctrl;

  logic       clk_MAC = 1'b0;
  logic       rst     = 1'b1;
  logic       start   = 1'b0;
  logic       busy, done, flag, wr_en;
  logic [2:0] count, count_reg, stage;
  logic [4:0] addr_a, addr_b, wr_addr_a, wr_addr_b;
  logic [3:0] tw_idx;

  logic [2:0] ag_stage = 3'd0;
  logic [3:0] ag_bf    = 4'd0;
  logic [4:0] ag_a, ag_b;
  logic [3:0] ag_tw;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_MAC = ~clk_MAC;

  fft_bf_ctrl dut (
    .clk_MAC   (clk_MAC),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .count     (count),
    .count_reg (count_reg),
    .flag      (flag),
    .stage     (stage),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .tw_idx    (tw_idx),
    .wr_en     (wr_en),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b)
  );

  fft_addr_gen u_ag (
    .stage_i  (ag_stage),
    .bf_idx_i (ag_bf),
    .addr_a_o (ag_a),
    .addr_b_o (ag_b),
    .tw_idx_o (ag_tw)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check_val({tag, "_busy"},  busy,      0);
    check_val({tag, "_done"},  done,      0);
    check_val({tag, "_count"}, count,     0);
    check_val({tag, "_creg"},  count_reg, 0);
    check_val({tag, "_flag"},  flag,      0);
    check_val({tag, "_stage"}, stage,     0);
    check_val({tag, "_addra"}, addr_a,    0);
    check_val({tag, "_addrb"}, addr_b,    0);
    check_val({tag, "_tw"},    tw_idx,    0);
    check_val({tag, "_wren"},  wr_en,     0);
    check_val({tag, "_wra"},   wr_addr_a, 0);
    check_val({tag, "_wrb"},   wr_addr_b, 0);
  endtask

  task automatic check_ag(input int s, input int bf, input int ea, input int eb, input int et);
    ag_stage = 3'(s);
    ag_bf    = 4'(bf);
    #1;
    check_val("ag_addr_a", ag_a,  ea);
    check_val("ag_addr_b", ag_b,  eb);
    check_val("ag_tw_idx", ag_tw, et);
  endtask

  // One transform observed cycle by cycle. Caller has start=1 set so the
  // next edge is edge 0; sample c is taken #1 after edge c-1.
  task automatic run_check(input int rst_cyc, input bit repulse, input bit restart);
    int  writes [32];
    int  flags, wrs, n_bad;
    bit  aborted, e_run;
    int  e_busy, e_done, e_cnt, e_flag, e_stage, e_bf, e_a, e_b, e_tw;
    int  k, s, r, span;
    int  p_cnt, p_flag, p_a, p_b;
    flags = 0; wrs = 0; aborted = 1'b0;
    p_cnt = 0; p_flag = 0; p_a = 0; p_b = 0;
    for (int i = 0; i < 32; i++) writes[i] = 0;
    for (int c = 1; c <= 332; c++) begin
      @(posedge clk_MAC);
      #1;
      start = 1'b0;
      rst   = 1'b0;
      if (rst_cyc > 0 && c == rst_cyc + 1) begin
        aborted = 1'b1;
        check_idle_zero("abort");
        p_cnt = 0; p_flag = 0;
      end
      e_run = 1'b0; e_busy = 0; e_done = 0; e_cnt = 0; e_stage = -1; e_bf = 0;
      if (aborted) begin
        e_stage = 0;
      end else if (c <= 328) begin
        k = c - 1; s = k / 66; r = k % 66;
        e_busy = 1; e_stage = s;
        if (r < 64) begin
          e_run = 1'b1; e_cnt = r % 4; e_bf = r / 4;
        end
      end else if (c <= 330) begin
        e_busy = 1;
      end else if (c == 331) begin
        e_busy = 1; e_done = 1;
      end
      e_flag = (e_run && e_cnt == 3) ? 1 : 0;
      check_val("busy",      busy,      e_busy);
      check_val("done",      done,      e_done);
      check_val("count",     count,     e_cnt);
      check_val("flag",      flag,      e_flag);
      check_val("count_reg", count_reg, p_cnt);
      check_val("wr_en",     wr_en,     p_flag);
      if (e_stage >= 0) check_val("stage", stage, e_stage);
      if (p_flag != 0) begin
        check_val("wr_addr_a", wr_addr_a, p_a);
        check_val("wr_addr_b", wr_addr_b, p_b);
      end
      if (e_run) begin
        span = 1 << e_stage;
        e_a  = e_bf + ((e_bf >> e_stage) << e_stage);
        e_b  = e_a + span;
        e_tw = (e_bf % span) * (16 >> e_stage);
        check_val("addr_a", addr_a, e_a);
        check_val("addr_b", addr_b, e_b);
        check_val("tw_idx", tw_idx, e_tw);
        p_a = e_a; p_b = e_b;
      end
      if (flag) flags++;
      if (wr_en) begin
        wrs++;
        writes[wr_addr_a]++;
        writes[wr_addr_b]++;
      end
      p_cnt  = e_cnt;
      p_flag = e_flag;
      if (aborted && c >= rst_cyc + 6) break;
      if (rst_cyc > 0 && c == rst_cyc) rst = 1'b1;
      if (repulse && (c == 50 || c == 331)) start = 1'b1;
      if (restart && c == 332) start = 1'b1;
    end
    if (rst_cyc == 0) begin
      check_val("flag_pulses", flags, 80);
      check_val("wr_pulses",   wrs,   80);
      n_bad = 0;
      for (int i = 0; i < 32; i++) if (writes[i] != 5) n_bad++;
      check_val("addrs_not_written_5x", n_bad, 0);
    end
  endtask

  initial begin
    // Reset held together with start: reset must win
    rst   = 1'b1;
    start = 1'b1;
    repeat (3) @(posedge clk_MAC);
    #1;
    check_idle_zero("reset");
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk_MAC);
    #1;
    check_idle_zero("post_reset");

    // Address generator corner vectors
    check_ag(0, 5,  10, 11, 0);
    check_ag(4, 5,  5,  21, 5);
    check_ag(2, 6,  10, 14, 8);
    check_ag(4, 15, 15, 31, 15);
    check_ag(0, 15, 30, 31, 0);

    // Full run with ignored re-starts, chained into an immediate second run
    start = 1'b1;
    run_check(0, 1'b1, 1'b1);
    run_check(0, 1'b0, 1'b0);

    // Reset mid-transform, then a clean full run
    start = 1'b1;
    run_check(100, 1'b0, 1'b0);
    start = 1'b1;
    run_check(0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
